// File: rtl/poweron_seq_ctrl.sv
// Power-up sequencer: brings STAGE_NUM rails/reset domains up in order with a settle
// delay and a power-good timeout per stage, then monitors all power-goods and latches faults.
module poweron_seq_ctrl #(
   parameter int SYSCLK_FREQ   = 125,
   parameter int STAGE_NUM     = 4,
   parameter int DELAY_US      = 1000,
   parameter int PG_TIMEOUT_US = 10000
) (
   input  logic                 i_Sys_clk,
   input  logic                 i_Rst,
   input  logic                 i_Start,
   input  logic                 i_Fault_clr,
   input  logic [STAGE_NUM-1:0] i_Pg,
   output logic [STAGE_NUM-1:0] o_En,
   output logic                 o_Busy,
   output logic                 o_Seq_done,
   output logic                 o_Fault,
   output logic [2:0]           o_Fault_stage
);

   localparam logic [31:0] DELAY_CYC  = 32'(DELAY_US * SYSCLK_FREQ);
   localparam logic [31:0] TO_CYC     = 32'(PG_TIMEOUT_US * SYSCLK_FREQ);
   localparam logic [2:0]  LAST_STAGE = 3'(STAGE_NUM - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_WAIT_PG,
      S_DONE,
      S_FAULT
   } state_t;

   state_t                 state_q, state_d;
   logic [2:0]             k_q, k_d;
   logic [31:0]            cnt_q, cnt_d;
   logic [STAGE_NUM-1:0]   en_q, en_d;
   logic [2:0]             fault_stage_q, fault_stage_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   fault_q, fault_d;

   logic [STAGE_NUM-1:0]   pg_meta_q, pg_s_q;
   logic [STAGE_NUM-1:0]   stage_onehot;
   logic [STAGE_NUM-1:0]   below_k;
   logic [STAGE_NUM-1:0]   mon_mask;
   logic [STAGE_NUM-1:0]   drop;
   logic                   drop_any;
   logic [2:0]             drop_idx;
   logic                   cur_pg;

   // i_Pg comes straight from regulator pins: two-flop synchronizer per bit
   for (genvar gi = 0; gi < STAGE_NUM; gi++) begin : g_sync
      always_ff @(posedge i_Sys_clk) begin
         if (i_Rst) begin
            pg_meta_q[gi] <= 1'b0;
            pg_s_q[gi]    <= 1'b0;
         end else begin
            pg_meta_q[gi] <= i_Pg[gi];
            pg_s_q[gi]    <= pg_meta_q[gi];
         end
      end
   end

   for (genvar gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
      assign stage_onehot[gi] = (k_q == 3'(gi));
      assign below_k[gi]      = (3'(gi) < k_q);
   end

   assign cur_pg = |(pg_s_q & stage_onehot);

   // Stages already switched on must keep their power-good; in DONE that is every stage
   always_comb begin
      mon_mask = '0;
      case (state_q)
         S_DELAY, S_WAIT_PG: mon_mask = below_k;
         S_DONE:             mon_mask = '1;
         default:            mon_mask = '0;
      endcase
   end

   assign drop     = mon_mask & ~pg_s_q;
   assign drop_any = |drop;

   always_comb begin
      drop_idx = 3'd0;
      for (int j = STAGE_NUM - 1; j >= 0; j--) begin
         if (drop[j]) drop_idx = 3'(j);
      end
   end

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      en_d          = en_q;
      fault_stage_d = fault_stage_q;

      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               state_d = S_DELAY;
               k_d     = 3'd0;
            end
         end

         S_DELAY: begin
            if (drop_any) begin
               state_d       = S_FAULT;
               en_d          = '0;
               fault_stage_d = drop_idx;
            end else if (cnt_q == DELAY_CYC - 32'd1) begin
               state_d = S_WAIT_PG;
               en_d    = en_q | stage_onehot;
            end
         end

         S_WAIT_PG: begin
            if (drop_any) begin
               state_d       = S_FAULT;
               en_d          = '0;
               fault_stage_d = drop_idx;
            end else if (cur_pg) begin
               // power-good beats a timeout landing on the same cycle
               if (k_q == LAST_STAGE) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_DELAY;
                  k_d     = k_q + 3'd1;
               end
            end else if (cnt_q == TO_CYC - 32'd1) begin
               state_d       = S_FAULT;
               en_d          = '0;
               fault_stage_d = k_q;
            end
         end

         S_DONE: begin
            en_d = '1;
            if (drop_any) begin
               state_d       = S_FAULT;
               en_d          = '0;
               fault_stage_d = drop_idx;
            end
         end

         S_FAULT: begin
            en_d = '0;
            if (i_Fault_clr) begin
               state_d       = S_IDLE;
               k_d           = 3'd0;
               fault_stage_d = 3'd0;
            end
         end

         default: begin
            state_d       = S_IDLE;
            k_d           = 3'd0;
            en_d          = '0;
            fault_stage_d = 3'd0;
         end
      endcase
   end

   // Counter restarts on every state change and only runs where it is compared
   always_comb begin
      cnt_d = 32'd0;
      if ((state_d == state_q) && ((state_q == S_DELAY) || (state_q == S_WAIT_PG))) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_comb begin
      busy_d  = (state_d == S_DELAY) || (state_d == S_WAIT_PG);
      done_d  = (state_d == S_DONE);
      fault_d = (state_d == S_FAULT);
   end

   always_ff @(posedge i_Sys_clk) begin
      if (i_Rst) begin
         state_q       <= S_IDLE;
         k_q           <= 3'd0;
         cnt_q         <= 32'd0;
         en_q          <= '0;
         fault_stage_q <= 3'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         cnt_q         <= cnt_d;
         en_q          <= en_d;
         fault_stage_q <= fault_stage_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         fault_q       <= fault_d;
      end
   end

   assign o_En          = en_q;
   assign o_Busy        = busy_q;
   assign o_Seq_done    = done_q;
   assign o_Fault       = fault_q;
   assign o_Fault_stage = fault_stage_q;

endmodule

// File: tb/tb_poweron_seq_ctrl.sv
// Bench for poweron_seq_ctrl: directed scenarios plus random runs; every cycle's
// outputs are predicted by an event-level model and compared by a monitor.
module tb_poweron_seq_ctrl;

   localparam int N        = 3;
   localparam int DLY      = 6;    // DELAY_US*SYSCLK_FREQ
   localparam int TO       = 10;   // PG_TIMEOUT_US*SYSCLK_FREQ
   localparam int P_IDLE   = 0;
   localparam int P_DELAY  = 1;
   localparam int P_WAIT   = 2;
   localparam int P_DONE   = 3;
   localparam int P_FAULT  = 4;

   logic         i_Sys_clk;
   logic         i_Rst;
   logic         i_Start;
   logic         i_Fault_clr;
   logic [N-1:0] i_Pg;
   logic [N-1:0] o_En;
   logic         o_Busy;
   logic         o_Seq_done;
   logic         o_Fault;
   logic [2:0]   o_Fault_stage;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [8:0] exp_q[$];

   // reference model state
   int       m_phase = P_IDLE;
   int       m_k     = 0;
   int       m_entry = 0;
   int       m_fs    = 0;
   bit [N-1:0] m_en  = '0;
   bit [N-1:0] h1    = '0;
   bit [N-1:0] h2    = '0;

   poweron_seq_ctrl #(
      .SYSCLK_FREQ   (2),
      .STAGE_NUM     (N),
      .DELAY_US      (3),
      .PG_TIMEOUT_US (5)
   ) dut (
      .i_Sys_clk     (i_Sys_clk),
      .i_Rst         (i_Rst),
      .i_Start       (i_Start),
      .i_Fault_clr   (i_Fault_clr),
      .i_Pg          (i_Pg),
      .o_En          (o_En),
      .o_Busy        (o_Busy),
      .o_Seq_done    (o_Seq_done),
      .o_Fault       (o_Fault),
      .o_Fault_stage (o_Fault_stage)
   );

   initial begin
      i_Sys_clk = 1'b0;
      forever #5 i_Sys_clk = ~i_Sys_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic go_fault(input int idx);
      m_phase = P_FAULT;
      m_en    = '0;
      m_fs    = idx;
   endtask

   // Applies the sequencing rules for one clock edge; elapsed = edges since state entry
   task automatic model_edge(input bit st, input bit cl, input bit rs, input bit [N-1:0] pg);
      bit [N-1:0] seen;
      bit [N-1:0] mask;
      int low;
      int elapsed;
      seen = h2;
      h2   = h1;
      h1   = pg;
      if (rs) begin
         m_phase = P_IDLE; m_k = 0; m_en = '0; m_fs = 0;
         h1 = '0; h2 = '0; m_entry = cyc;
         return;
      end
      mask = '0;
      if (m_phase == P_DONE) mask = '1;
      else if (m_phase == P_DELAY || m_phase == P_WAIT)
         for (int j = 0; j < m_k; j++) mask[j] = 1'b1;
      low = -1;
      for (int j = N - 1; j >= 0; j--) if (mask[j] && !seen[j]) low = j;
      elapsed = cyc - m_entry;
      case (m_phase)
         P_IDLE:  if (st) begin m_phase = P_DELAY; m_k = 0; m_entry = cyc; end
         P_DELAY: begin
            if (low >= 0) go_fault(low);
            else if (elapsed == DLY) begin
               m_en[m_k] = 1'b1; m_phase = P_WAIT; m_entry = cyc;
            end
         end
         P_WAIT: begin
            if (low >= 0) go_fault(low);
            else if (seen[m_k]) begin
               if (m_k == N - 1) m_phase = P_DONE;
               else begin m_k++; m_phase = P_DELAY; end
               m_entry = cyc;
            end else if (elapsed == TO) go_fault(m_k);
         end
         P_DONE:  if (low >= 0) go_fault(low);
         P_FAULT: if (cl) begin m_phase = P_IDLE; m_fs = 0; m_k = 0; end
         default: ;
      endcase
   endtask

   task automatic tick(input bit st, input bit cl, input bit rs);
      bit busy;
      i_Start = st; i_Fault_clr = cl; i_Rst = rs;
      @(posedge i_Sys_clk);
      cyc++;
      model_edge(st, cl, rs, i_Pg);
      busy = (m_phase == P_DELAY) || (m_phase == P_WAIT);
      exp_q.push_back({m_en, busy, m_phase == P_DONE, m_phase == P_FAULT, 3'(m_fs)});
      #1;
      i_Start = 1'b0; i_Fault_clr = 1'b0; i_Rst = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge i_Sys_clk) begin
      logic [8:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {o_En, o_Busy, o_Seq_done, o_Fault, o_Fault_stage};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL scoreboard edge %0d: got en=%b busy=%b done=%b fault=%b fs=%0d, expected en=%b busy=%b done=%b fault=%b fs=%0d",
                     cyc, a[8:6], a[5], a[4], a[3], a[2:0], e[8:6], e[5], e[4], e[3], e[2:0]);
         end
      end
   end

   task automatic wait_en(input int k);
      for (int i = 0; i < 60; i++) begin
         if (o_En[k]) break;
         tick(0, 0, 0);
      end
      chk($sformatf("wait_en%0d", k), 32'(o_En[k]), 32'd1);
   endtask

   // Nominal bring-up: pg[k] sampled 4 edges after en[k] rises
   task automatic nominal(input bit extra_start);
      int s;
      int rise[N];
      i_Pg = '0;
      tick(1, 0, 0);
      s = cyc;
      if (extra_start) begin
         tick(0, 0, 0);
         tick(1, 0, 0);
      end
      for (int k = 0; k < N; k++) begin
         wait_en(k);
         rise[k] = cyc;
         repeat (3) tick(0, 0, 0);
         i_Pg[k] = 1'b1;
         tick(0, 0, 0);
      end
      repeat (2) tick(0, 0, 0);
      chk("done_after_last_pg", 32'(o_Seq_done), 32'd1);
      chk("en0_latency", 32'(rise[0] - s), 32'(DLY));
      chk("en1_spacing", 32'(rise[1] - rise[0]), 32'd12);
      chk("en2_spacing", 32'(rise[2] - rise[1]), 32'd12);
   endtask

   task automatic brownout();
      i_Pg = 3'b010;
      tick(0, 0, 0);
      tick(0, 0, 0);
      chk("brownout_early", 32'(o_Fault), 32'd0);
      tick(0, 0, 0);
      chk("brownout_fault", 32'({o_Fault, o_Fault_stage, o_En}), 32'({1'b1, 3'd0, 3'b000}));
      i_Pg = '0;
      tick(0, 1, 0);
      chk("brownout_clear", 32'({o_En, o_Busy, o_Seq_done, o_Fault, o_Fault_stage}), 32'd0);
   endtask

   initial begin
      int e0;
      int d;
      i_Rst = 1'b1; i_Start = 1'b0; i_Fault_clr = 1'b0; i_Pg = '0;
      repeat (3) tick(0, 0, 1);
      chk("reset_outputs", 32'({o_En, o_Busy, o_Seq_done, o_Fault, o_Fault_stage}), 32'd0);

      // nominal with an ignored mid-DELAY start, then brown-out in DONE
      nominal(1'b1);
      brownout();

      // timeout on stage 1, then clear together with start
      i_Pg = '0;
      tick(1, 0, 0);
      wait_en(0);
      tick(0, 0, 0);
      i_Pg[0] = 1'b1;
      tick(0, 0, 0);
      wait_en(1);
      repeat (9) tick(0, 0, 0);
      chk("timeout_early", 32'(o_Fault), 32'd0);
      tick(0, 0, 0);
      chk("timeout_fault", 32'({o_Fault, o_Fault_stage, o_En}), 32'({1'b1, 3'd1, 3'b000}));
      tick(1, 1, 0);
      chk("clr_with_start", 32'({o_En, o_Busy, o_Seq_done, o_Fault, o_Fault_stage}), 32'd0);
      repeat (8) tick(0, 0, 0);
      chk("no_restart", 32'({o_En, o_Busy}), 32'd0);

      // pg seen exactly on the timeout cycle, then reset inside stage-1 WAIT_PG
      i_Pg = '0;
      tick(1, 0, 0);
      wait_en(0);
      e0 = cyc;
      repeat (7) tick(0, 0, 0);
      i_Pg[0] = 1'b1;
      tick(0, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      chk("race_no_fault", 32'(o_Fault), 32'd0);
      chk("race_edge", 32'(cyc - e0), 32'(TO));
      repeat (5) tick(0, 0, 0);
      chk("race_en_hold", 32'(o_En), 32'b001);
      tick(0, 0, 0);
      chk("race_advance", 32'(o_En), 32'b011);
      repeat (3) tick(0, 0, 0);
      i_Pg = '0;
      tick(0, 0, 1);
      chk("mid_reset", 32'({o_En, o_Busy, o_Seq_done, o_Fault, o_Fault_stage}), 32'd0);
      nominal(1'b0);
      brownout();

      // random runs checked only by the scoreboard
      for (int it = 0; it < 30; it++) begin
         i_Pg = '0;
         repeat ($urandom_range(3, 6)) tick(0, 0, 0);
         tick(1, 0, 0);
         for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 40 && !m_en[k] && m_phase != P_FAULT; i++)
               tick(1'($urandom_range(0, 1)), 0, 0);
            if (m_phase == P_FAULT) break;
            d = $urandom_range(1, 10);
            repeat (d - 1) tick(0, 0, 0);
            if (m_phase == P_FAULT) break;
            if (k > 0 && $urandom_range(0, 5) == 0) i_Pg[$urandom_range(0, k - 1)] = 1'b0;
            i_Pg[k] = 1'b1;
            tick(0, 0, 0);
         end
         repeat (12) tick(0, 0, 0);
         if (m_phase == P_DONE) begin
            i_Pg = i_Pg & 3'($urandom_range(0, 6));
            repeat (4) tick(0, 0, 0);
         end
         if (m_phase == P_FAULT) tick(1'($urandom_range(0, 1)), 1, 0);
         else tick(0, 0, 1);
      end

      @(negedge i_Sys_clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
